// File: rtl/spi_frame_decoder.sv
// SPI slave frame decoder: MSB-first opcode/payload bytes become register writes, command
// pulses and feedback readbacks, with an inactivity timeout and silent abort on cs_n high.
module spi_frame_decoder #(
  parameter int unsigned ADDR_W         = 5,
  parameter int unsigned DATA_BYTES     = 2,
  parameter int unsigned FB_BYTES       = 4,
  parameter logic [7:0]  READ_OPCODE    = 8'hAB,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic                    clk_in,
  input  logic                    sys_rst,
  input  logic                    sclk,
  input  logic                    mosi,
  input  logic                    cs_n,
  output logic                    miso,
  output logic                    wr_valid,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [8*DATA_BYTES-1:0] wr_data,
  output logic                    cmd_valid,
  output logic [6:0]              cmd_code,
  output logic                    fb_req,
  input  logic [8*FB_BYTES-1:0]   fb_data,
  output logic                    frame_err
);

  localparam int unsigned DW       = 8 * DATA_BYTES;
  localparam int unsigned FW       = 8 * FB_BYTES;
  localparam int unsigned MaxBytes = (DATA_BYTES > FB_BYTES) ? DATA_BYTES : FB_BYTES;
  localparam int unsigned BcW      = $clog2(MaxBytes + 1);
  localparam int unsigned TcW      = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StPayload, StRead} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, csn_sync_q;
  logic                   sclk_prev_q;

  // cs_n synchroniser resets to the deselected level
  always_ff @(posedge clk_in or posedge sys_rst) begin
    if (sys_rst) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      csn_sync_q  <= '1;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= (sclk_sync_q << 1) | SYNC_STAGES'(sclk);
      mosi_sync_q <= (mosi_sync_q << 1) | SYNC_STAGES'(mosi);
      csn_sync_q  <= (csn_sync_q << 1) | SYNC_STAGES'(cs_n);
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
    end
  end

  state_e          state_q;
  logic [2:0]      bit_cnt_q;
  logic [BcW-1:0]  byte_cnt_q;
  logic [TcW-1:0]  idle_cnt_q;
  logic [6:0]      rx_q;
  logic [FW-2:0]   tx_q;
  logic [DW-1:0]   pay_q;
  logic [ADDR_W-1:0] addr_q;
  logic            miso_q, wr_valid_q, cmd_valid_q, fb_req_q, frame_err_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DW-1:0]   wr_data_q;
  logic [6:0]      cmd_code_q;

  logic          sclk_s, mosi_s, cs_hi, rise, byte_done, active, timeout;
  logic [7:0]    rx_byte;
  logic [DW-1:0] pay_next;

  always_comb begin
    sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    cs_hi     = csn_sync_q[SYNC_STAGES-1];
    rise      = sclk_s & ~sclk_prev_q;
    rx_byte   = {rx_q, mosi_s};
    byte_done = rise && (bit_cnt_q == 3'd7);
    active    = (state_q != StIdle) || (bit_cnt_q != 3'd0);
    timeout   = active && !rise && (idle_cnt_q == TcW'(TIMEOUT_CYCLES - 1));
    pay_next  = pay_q;
    pay_next[{byte_cnt_q, 3'b000} +: 8] = rx_byte;
  end

  always_ff @(posedge clk_in or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      idle_cnt_q  <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      pay_q       <= '0;
      addr_q      <= '0;
      miso_q      <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= '0;
      fb_req_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      wr_valid_q  <= 1'b0;
      cmd_valid_q <= 1'b0;
      fb_req_q    <= 1'b0;
      frame_err_q <= 1'b0;
      if (cs_hi || timeout) begin
        // cs_n high wins over any coincident edge; only the timeout reports an error
        state_q     <= StIdle;
        bit_cnt_q   <= '0;
        byte_cnt_q  <= '0;
        idle_cnt_q  <= '0;
        rx_q        <= '0;
        miso_q      <= 1'b0;
        frame_err_q <= !cs_hi;
      end else begin
        if (rise || !active) idle_cnt_q <= '0;
        else                 idle_cnt_q <= idle_cnt_q + TcW'(1);
        if (rise) begin
          bit_cnt_q <= bit_cnt_q + 3'd1;
          rx_q      <= rx_byte[6:0];
          case (state_q)
            StIdle: begin
              if (byte_done) begin
                if (rx_byte == READ_OPCODE) begin
                  tx_q       <= fb_data[FW-2:0];
                  miso_q     <= fb_data[FW-1];
                  fb_req_q   <= 1'b1;
                  byte_cnt_q <= '0;
                  state_q    <= StRead;
                end else if (rx_byte[7]) begin
                  addr_q     <= rx_byte[ADDR_W-1:0];
                  byte_cnt_q <= '0;
                  state_q    <= StPayload;
                end else begin
                  cmd_valid_q <= 1'b1;
                  cmd_code_q  <= rx_byte[6:0];
                end
              end
            end
            StPayload: begin
              if (byte_done) begin
                if (byte_cnt_q == BcW'(DATA_BYTES - 1)) begin
                  wr_valid_q <= 1'b1;
                  wr_addr_q  <= addr_q;
                  wr_data_q  <= pay_next;
                  byte_cnt_q <= '0;
                  state_q    <= StIdle;
                end else begin
                  pay_q      <= pay_next;
                  byte_cnt_q <= byte_cnt_q + BcW'(1);
                end
              end
            end
            StRead: begin
              // next bit appears a few clk after the rising edge, ahead of the master's
              // falling-edge sample
              tx_q   <= {tx_q[FW-3:0], 1'b0};
              miso_q <= tx_q[FW-2];
              if (byte_done) begin
                if (byte_cnt_q == BcW'(FB_BYTES - 1)) begin
                  miso_q     <= 1'b0;
                  byte_cnt_q <= '0;
                  state_q    <= StIdle;
                end else begin
                  byte_cnt_q <= byte_cnt_q + BcW'(1);
                end
              end
            end
            default: state_q <= StIdle;
          endcase
        end
      end
    end
  end

  assign miso      = miso_q;
  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_code  = cmd_code_q;
  assign fb_req    = fb_req_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_frame_decoder.sv
// Bench for spi_frame_decoder: frame table, directed corner sequences and a randomised
// frame stream checked against a byte-level protocol model.
module tb_spi_frame_decoder;

  logic        clk_in = 1'b0;
  logic        sys_rst = 1'b1;
  logic        sclk = 1'b0;
  logic        mosi = 1'b0;
  logic        cs_n = 1'b1;
  logic        miso;
  logic        wr_valid;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic        cmd_valid;
  logic [6:0]  cmd_code;
  logic        fb_req;
  logic [31:0] fb_data = 32'h0;
  logic        frame_err;

  spi_frame_decoder dut (
    .clk_in    (clk_in),
    .sys_rst   (sys_rst),
    .sclk      (sclk),
    .mosi      (mosi),
    .cs_n      (cs_n),
    .miso      (miso),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .fb_req    (fb_req),
    .fb_data   (fb_data),
    .frame_err (frame_err)
  );

  always #10 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;

  // Event monitor, sampled on the falling clock edge
  int          wr_cnt = 0, cmd_cnt = 0, fbreq_cnt = 0, ferr_cnt = 0;
  logic [20:0] wr_q[$];
  logic [6:0]  cmd_q[$];

  always @(negedge clk_in) begin
    if (wr_valid) begin
      wr_cnt++;
      wr_q.push_back({wr_addr, wr_data});
    end
    if (cmd_valid) begin
      cmd_cnt++;
      cmd_q.push_back(cmd_code);
    end
    if (fb_req) fbreq_cnt++;
    if (frame_err) ferr_cnt++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    #(20 * n);
  endtask

  // One SPI bit per 60 ns; miso is sampled just before each falling edge
  task automatic send_bits(input logic [7:0] b, input int nbits, output logic [7:0] samp);
    samp = 8'h0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi = b[i];
      #30 sclk = 1'b1;
      #30 samp = {samp[6:0], miso};
      sclk = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic [7:0] samp);
    send_bits(b, 8, samp);
  endtask

  typedef struct {
    logic [7:0]  b0, b1, b2;
    int          n;
    int          n_wr;
    logic [4:0]  addr;
    logic [15:0] data;
    int          n_cmd;
    logic [6:0]  code;
  } vec_t;

  vec_t        vecs[7];
  logic [7:0]  s;
  logic [7:0]  op, d0, d1;
  logic [31:0] fbv;
  int          w0, c0, f0, e0;
  logic [20:0] exp_wr[$];
  logic [6:0]  exp_cmd[$];
  logic [7:0]  exp_rd[$], got_rd[$];
  int          exp_fb;

  initial begin
    vecs[0] = '{8'h91, 8'h64, 8'h00, 3, 1, 5'h11, 16'h0064, 0, 7'h00};
    vecs[1] = '{8'h9C, 8'h01, 8'h20, 3, 1, 5'h1C, 16'h2001, 0, 7'h00};
    vecs[2] = '{8'h06, 8'h00, 8'h00, 1, 0, 5'h00, 16'h0000, 1, 7'h06};
    vecs[3] = '{8'h80, 8'hFF, 8'hEE, 3, 1, 5'h00, 16'hEEFF, 0, 7'h00};
    vecs[4] = '{8'h7F, 8'h00, 8'h00, 1, 0, 5'h00, 16'h0000, 1, 7'h7F};
    vecs[5] = '{8'hE5, 8'h00, 8'h80, 3, 1, 5'h05, 16'h8000, 0, 7'h00};
    vecs[6] = '{8'h00, 8'h00, 8'h00, 1, 0, 5'h00, 16'h0000, 1, 7'h00};

    // Reset state
    wait_clk(3);
    check("reset outputs",
          {miso, wr_valid, wr_addr, wr_data, cmd_valid, cmd_code, fb_req, frame_err}, 64'h0);
    @(posedge clk_in);
    #5 sys_rst = 1'b0;
    cs_n = 1'b0;
    wait_clk(5);

    // Table of single frames, cs_n held low throughout
    foreach (vecs[i]) begin
      w0 = wr_cnt;
      c0 = cmd_cnt;
      send_byte(vecs[i].b0, s);
      if (vecs[i].n > 1) send_byte(vecs[i].b1, s);
      if (vecs[i].n > 2) send_byte(vecs[i].b2, s);
      wait_clk(8);
      check($sformatf("vec%0d wr pulses", i), 64'(wr_cnt - w0), 64'(vecs[i].n_wr));
      check($sformatf("vec%0d cmd pulses", i), 64'(cmd_cnt - c0), 64'(vecs[i].n_cmd));
      if (vecs[i].n_wr == 1) begin
        check($sformatf("vec%0d wr_addr", i), 64'(wr_addr), 64'(vecs[i].addr));
        check($sformatf("vec%0d wr_data", i), 64'(wr_data), 64'(vecs[i].data));
      end
      if (vecs[i].n_cmd == 1 && cmd_q.size() > 0)
        check($sformatf("vec%0d cmd_code", i), 64'(cmd_q[$]), 64'(vecs[i].code));
    end

    // Feedback read followed by a command
    fb_data = 32'h12345678;
    f0 = fbreq_cnt;
    c0 = cmd_cnt;
    send_byte(8'hAB, s);
    send_byte(8'hFF, s); check("read byte0", 64'(s), 64'h12);
    send_byte(8'hFF, s); check("read byte1", 64'(s), 64'h34);
    send_byte(8'hFF, s); check("read byte2", 64'(s), 64'h56);
    send_byte(8'hFF, s); check("read byte3", 64'(s), 64'h78);
    wait_clk(5);
    check("fb_req pulses", 64'(fbreq_cnt - f0), 64'd1);
    check("miso after read", 64'(miso), 64'd0);
    send_byte(8'h06, s);
    wait_clk(5);
    check("cmd after read", 64'(cmd_cnt - c0), 64'd1);
    check("cmd code after read", 64'(cmd_q[$]), 64'h06);

    // Inactivity timeout mid-payload
    w0 = wr_cnt;
    e0 = ferr_cnt;
    send_byte(8'h93, s);
    send_byte(8'h50, s);
    wait_clk(950);
    check("no frame_err before timeout", 64'(ferr_cnt - e0), 64'd0);
    wait_clk(150);
    check("frame_err pulses", 64'(ferr_cnt - e0), 64'd1);
    check("no wr on timeout", 64'(wr_cnt - w0), 64'd0);
    send_byte(8'h93, s);
    send_byte(8'h50, s);
    send_byte(8'h00, s);
    wait_clk(5);
    check("wr after timeout", 64'(wr_cnt - w0), 64'd1);
    check("addr/data after timeout", 64'({wr_addr, wr_data}), 64'({5'h13, 16'h0050}));

    // Silent abort by cs_n, then a long idle that must not time out
    w0 = wr_cnt;
    e0 = ferr_cnt;
    send_bits(8'h9E, 5, s);
    wait_clk(2);
    cs_n = 1'b1;
    wait_clk(10);
    cs_n = 1'b0;
    wait_clk(1100);
    send_byte(8'h9E, s);
    send_byte(8'h32, s);
    send_byte(8'h00, s);
    wait_clk(5);
    check("no frame_err on cs abort", 64'(ferr_cnt - e0), 64'd0);
    check("wr after cs abort", 64'(wr_cnt - w0), 64'd1);
    check("addr/data after cs abort", 64'({wr_addr, wr_data}), 64'({5'h1E, 16'h0032}));

    // Reset mid-payload
    w0 = wr_cnt;
    send_byte(8'h91, s);
    send_byte(8'h64, s);
    wait_clk(2);
    sys_rst = 1'b1;
    wait_clk(3);
    check("outputs in mid-frame reset",
          {miso, wr_valid, wr_addr, wr_data, cmd_valid, cmd_code, fb_req, frame_err}, 64'h0);
    sys_rst = 1'b0;
    wait_clk(5);
    check("no wr from reset frame", 64'(wr_cnt - w0), 64'd0);
    send_byte(8'h91, s);
    send_byte(8'h64, s);
    send_byte(8'h00, s);
    wait_clk(5);
    check("wr after reset", 64'(wr_cnt - w0), 64'd1);
    check("addr/data after reset", 64'({wr_addr, wr_data}), 64'({5'h11, 16'h0064}));

    // Random back-to-back frames against a byte-stream model
    wr_q.delete();
    cmd_q.delete();
    f0 = fbreq_cnt;
    e0 = ferr_cnt;
    exp_fb = 0;
    for (int f = 0; f < 30; f++) begin
      op = 8'($urandom);
      if ($urandom_range(0, 3) == 0) op = 8'hAB;
      if (op == 8'hAB) begin
        fbv = $urandom;
        fb_data = fbv;
        exp_fb++;
        send_byte(op, s);
        for (int k = 0; k < 4; k++) begin
          exp_rd.push_back(8'(fbv >> (24 - 8 * k)));
          send_byte(8'($urandom), s);
          got_rd.push_back(s);
        end
      end else if (op[7]) begin
        d0 = 8'($urandom);
        d1 = 8'($urandom);
        exp_wr.push_back({op[4:0], d1, d0});
        send_byte(op, s);
        send_byte(d0, s);
        send_byte(d1, s);
      end else begin
        exp_cmd.push_back(op[6:0]);
        send_byte(op, s);
      end
    end
    wait_clk(10);
    check("rnd wr count", 64'(wr_q.size()), 64'(exp_wr.size()));
    for (int i = 0; i < wr_q.size() && i < exp_wr.size(); i++)
      check($sformatf("rnd wr %0d", i), 64'(wr_q[i]), 64'(exp_wr[i]));
    check("rnd cmd count", 64'(cmd_q.size()), 64'(exp_cmd.size()));
    for (int i = 0; i < cmd_q.size() && i < exp_cmd.size(); i++)
      check($sformatf("rnd cmd %0d", i), 64'(cmd_q[i]), 64'(exp_cmd[i]));
    check("rnd fb_req count", 64'(fbreq_cnt - f0), 64'(exp_fb));
    check("rnd frame_err count", 64'(ferr_cnt - e0), 64'd0);
    for (int i = 0; i < got_rd.size(); i++)
      check($sformatf("rnd read byte %0d", i), 64'(got_rd[i]), 64'(exp_rd[i]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
